tlul_host_adapter: RTL and testbench
====================================

// Module: tlul_host_adapter
// PURPOSE
//  Initiator side of TL-UL: turns a simple req/gnt register-access port into TL-UL A-channel requests.
//  Collects the D-channel response and returns read data or an error.
//  Lets a master (debug UART bridge, DMA, test sequencer) drive tlul_pkg devices such as the UART register block.
//  Single outstanding transaction; 32-bit word accesses only.
// PARAMETERS
//  AW        32     address width, driven onto a_address
//  DW        32     data width; only 32 is supported
//  SourceId  0      value driven onto a_source; also the only d_source accepted
// PORTS
//  clk_i     in   1        clock
//  rst_ni    in   1        asynchronous active-low reset
//  req_i     in   1        access request; hold until gnt_o
//  gnt_o     out  1        request accepted this cycle (comb: req_i & state==IDLE)
//  we_i      in   1        1=write 0=read
//  addr_i    in   AW       byte address
//  wdata_i   in   DW       write data
//  be_i      in   DW/8     byte enables
//  rvalid_o  out  1        one-cycle response strobe
//  rdata_o   out  DW       read data; valid with rvalid_o
//  err_o     out  1        error; valid with rvalid_o
//  busy_o    out  1        state != IDLE
//  tl_o      out  tl_h2d_t A channel + d_ready
//  tl_i      in   tl_d2h_t D channel + a_ready
// BEHAVIOUR
//  Reset values: all tl_o fields 0; gnt_o, rvalid_o, err_o, busy_o = 0; rdata_o = 0; state = IDLE.
//  FSM states: IDLE, ADDR, DATA.
//   IDLE, req_i=1: gnt_o=1 in the same cycle; register we/addr/wdata/be; next state ADDR.
//   ADDR: a_valid=1; A-channel fields come from the registered copies and stay stable until a_ready.
//     On a_valid & a_ready, next state DATA.
//   DATA: d_ready=1. On d_valid, next state IDLE.
//     The next cycle: rvalid_o=1, rdata_o=d_data (0 for writes), err_o=d_error|mismatch.
//  A-channel encoding:
//   a_opcode: read=Get(4); write with be==4'hF is PutFullData(0); other writes are PutPartialData(1).
//   a_size=2; a_mask=be; a_source=SourceId; a_param=0; a_user=default.
//  Mismatch (sets err_o):
//   d_source != SourceId;
//   d_opcode != AccessAckData(1) on a read;
//   d_opcode != AccessAck(0) on a write.
//  d_ready=0 outside DATA. A d_valid seen in IDLE or ADDR is ignored and not consumed.
//  Latency with a zero-wait device (a_ready=1, d_valid the cycle after the A handshake):
//   gnt at T0, A handshake at T1, D handshake at T2, rvalid_o at T3.
//   Next gnt_o is possible at T3 (FSM back in IDLE during T3).
//  req_i outside IDLE: gnt_o=0; the request waits. gnt_o never asserts while busy_o=1.
//  rvalid_o is a single-cycle pulse. rdata_o/err_o hold their values until the next rvalid_o.
//  Reset mid-transaction: immediate return to IDLE, a_valid/d_ready drop asynchronously.
//   The in-flight response is lost and no rvalid_o is generated.
//  Back-pressure: a_ready low for N cycles stretches ADDR by N cycles with the A fields unchanged.
// CONFIGURATION
//  TLUL_HOST_ALIGN_CHK_EN defined:
//   Checked in IDLE when req_i is granted: addr_i[1:0]!=0, or be_i==0 on a write.
//   Such a request is granted but no A transaction is issued.
//   The next cycle gives rvalid_o=1, err_o=1, rdata_o=0.
//  TLUL_HOST_ALIGN_CHK_EN undefined: no checks; addr_i and be_i are passed through unchanged.
// TESTING
//  1. Read addr=0x10, be=F; device a_ready=1, returns d_data=0xA5A5_0001 one cycle later
//     -> a_opcode=4, a_mask=F; rvalid_o at T3; rdata_o=0xA5A5_0001; err_o=0.
//  2. Write addr=0x04, wdata=0x55, be=0x1 -> a_opcode=1, a_mask=0x1, a_data=0x55;
//     AccessAck returned -> rvalid_o=1, err_o=0.
//  3. a_ready held low 5 cycles -> a_valid held 5+1 cycles with fields stable; gnt_o=0 for a second req_i.
//  4. Device returns d_error=1, or d_source=SourceId+1 -> err_o=1 with rvalid_o.
//  5. Assert rst_ni=0 while in DATA -> next cycle a_valid=0, d_ready=0, busy_o=0; no rvalid_o afterwards.
//  6. With TLUL_HOST_ALIGN_CHK_EN, req addr=0x13 -> no a_valid ever; rvalid_o=1, err_o=1 one cycle after gnt_o.

Source files
------------

// File: rtl/tlul_host_adapter.sv
// TL-UL host adapter: single-outstanding req/gnt register port -> TL-UL A/D channels.
// Optional macro TLUL_HOST_ALIGN_CHK_EN rejects misaligned or empty-mask requests locally.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  localparam logic [15:0] A_USER_DEFAULT = 16'h0000;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam int unsigned H2D_W = $bits(tl_h2d_t);
  localparam int unsigned D2H_W = $bits(tl_d2h_t);

endpackage

// tlul_host_adapter: grant in IDLE, one A beat, one D beat, then a one-cycle rvalid_o strobe.
// Latency: gnt T0, A handshake T1, D handshake T2, rvalid_o T3 (zero-wait device).
// Backpressure: a_ready low stretches ADDR with stable fields; d_ready only asserted in DATA.
module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter logic [7:0]  SourceId = 8'd0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic                we_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DW-1:0]       wdata_i,
  input  logic [DW/8-1:0]     be_i,
  output logic                rvalid_o,
  output logic [DW-1:0]       rdata_o,
  output logic                err_o,
  output logic                busy_o,
  output logic [H2D_W-1:0]    tl_o,
  input  logic [D2H_W-1:0]    tl_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] be_q;
  logic [2:0]      opcode_q;

  tl_h2d_t h2d;
  tl_d2h_t d2h;

  logic req_bad;
  logic a_hs;
  logic d_hs;
  logic rsp_mismatch;
  logic unused_d2h;

  assign d2h  = tl_d2h_t'(tl_i);
  assign tl_o = h2d;

  // Response fields the adapter has no use for.
  assign unused_d2h = ^{d2h.d_param, d2h.d_size, d2h.d_sink, d2h.d_user};

`ifdef TLUL_HOST_ALIGN_CHK_EN
  assign req_bad = (addr_i[1:0] != 2'b00) || (we_i && (be_i == '0));
`else
  assign req_bad = 1'b0;
`endif

  assign gnt_o  = req_i && (state_q == IDLE);
  assign busy_o = (state_q != IDLE);
  assign a_hs   = (state_q == ADDR) && d2h.a_ready;
  assign d_hs   = (state_q == DATA) && d2h.d_valid;

  assign rsp_mismatch = (d2h.d_source != SourceId) ||
                        (we_q ? (d2h.d_opcode != AccessAck) : (d2h.d_opcode != AccessAckData));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_o && !req_bad) state_d = ADDR;
      ADDR:    if (a_hs) state_d = DATA;
      DATA:    if (d_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A payload is zero outside ADDR so an idle bus never shows stale request fields.
  always_comb begin
    h2d         = '0;
    h2d.d_ready = (state_q == DATA);
    if (state_q == ADDR) begin
      h2d.a_valid   = 1'b1;
      h2d.a_opcode  = opcode_q;
      h2d.a_param   = 3'h0;
      h2d.a_size    = 2'd2;
      h2d.a_source  = SourceId;
      h2d.a_address = 32'(addr_q);
      h2d.a_mask    = 4'(be_q);
      h2d.a_data    = 32'(wdata_q);
      h2d.a_user    = A_USER_DEFAULT;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      opcode_q <= 3'h0;
    end else if (gnt_o) begin
      we_q     <= we_i;
      addr_q   <= addr_i;
      wdata_q  <= wdata_i;
      be_q     <= be_i;
      if (!we_i) begin
        opcode_q <= Get;
      end else if (be_i == '1) begin
        opcode_q <= PutFullData;
      end else begin
        opcode_q <= PutPartialData;
      end
    end
  end

  // rdata_o/err_o only move when a new strobe is produced.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      if (d_hs) begin
        rvalid_o <= 1'b1;
        rdata_o  <= we_q ? '0 : DW'(d2h.d_data);
        err_o    <= d2h.d_error | rsp_mismatch;
      end else if (gnt_o && req_bad) begin
        rvalid_o <= 1'b1;
        rdata_o  <= '0;
        err_o    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed self-checking bench for tlul_host_adapter with a hand-driven TL-UL device.
module tb_tlul_host_adapter;
  import tlul_pkg::*;

  logic             clk_i;
  logic             rst_ni;
  logic             req_i;
  logic             gnt_o;
  logic             we_i;
  logic [31:0]      addr_i;
  logic [31:0]      wdata_i;
  logic [3:0]       be_i;
  logic             rvalid_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic             busy_o;
  logic [H2D_W-1:0] tl_o;
  logic [D2H_W-1:0] tl_i;

  tl_h2d_t h2d;
  tl_d2h_t d2h;

  int checks = 0;
  int errors = 0;

  assign h2d  = tl_h2d_t'(tl_o);
  assign tl_i = d2h;

  tlul_host_adapter #(.AW(32), .DW(32), .SourceId(8'd0)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .be_i     (be_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .busy_o   (busy_o),
    .tl_o     (tl_o),
    .tl_i     (tl_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Zero-wait device run of one transaction; leaves the bench 2ns into the rvalid_o cycle.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [2:0] dop, input logic [7:0] dsrc,
                        input logic derr, input logic [31:0] ddata,
                        output logic got_gnt, output tl_h2d_t a_seen,
                        output logic rv, output logic [31:0] rd, output logic er);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
    d2h.a_ready = 1'b1;
    #1 got_gnt = gnt_o;
    tick;
    req_i = 1'b0;
    #1 a_seen = h2d;
    tick;
    d2h.d_valid = 1'b1; d2h.d_opcode = dop; d2h.d_source = dsrc;
    d2h.d_error = derr; d2h.d_data = ddata;
    tick;
    d2h.d_valid = 1'b0; d2h.d_error = 1'b0; d2h.d_source = 8'd0;
    #1 rv = rvalid_o; rd = rdata_o; er = err_o;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    d2h = '0;
    repeat (2) @(posedge clk_i);
    #2;
    checks++; if (tl_o !== '0) begin errors++; $display("FAIL rst_tl_o got %h exp 0", tl_o); end
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", gnt_o); end
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", rvalid_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_read;
    tick;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; be_i = 4'hF; d2h.a_ready = 1'b1;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b exp 1", gnt_o); end
    tick;
    req_i = 1'b0;
    #1;
    checks++; if (h2d.a_valid !== 1'b1) begin errors++; $display("FAIL rd_a_valid got %b exp 1", h2d.a_valid); end
    checks++; if (h2d.a_opcode !== 3'h4) begin errors++; $display("FAIL rd_a_opcode got %h exp 4", h2d.a_opcode); end
    checks++; if (h2d.a_mask !== 4'hF) begin errors++; $display("FAIL rd_a_mask got %h exp f", h2d.a_mask); end
    checks++; if (h2d.a_address !== 32'h10) begin errors++; $display("FAIL rd_a_address got %h exp 10", h2d.a_address); end
    checks++; if (h2d.a_size !== 2'd2) begin errors++; $display("FAIL rd_a_size got %0d exp 2", h2d.a_size); end
    checks++; if (h2d.d_ready !== 1'b0) begin errors++; $display("FAIL rd_d_ready_addr got %b exp 0", h2d.d_ready); end
    tick;
    d2h.d_valid = 1'b1; d2h.d_opcode = 3'h1; d2h.d_source = 8'd0; d2h.d_error = 1'b0; d2h.d_data = 32'hA5A5_0001;
    #1;
    checks++; if (h2d.d_ready !== 1'b1) begin errors++; $display("FAIL rd_d_ready got %b exp 1", h2d.d_ready); end
    checks++; if (h2d.a_valid !== 1'b0) begin errors++; $display("FAIL rd_a_valid_data got %b exp 0", h2d.a_valid); end
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_rvalid_early got %b exp 0", rvalid_o); end
    tick;
    d2h.d_valid = 1'b0;
    #1;
    checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL rd_rvalid_t3 got %b exp 1", rvalid_o); end
    checks++; if (rdata_o !== 32'hA5A5_0001) begin errors++; $display("FAIL rd_rdata got %h exp a5a50001", rdata_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rd_busy_t3 got %b exp 0", busy_o); end
    tick;
    #1;
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse got %b exp 0", rvalid_o); end
    checks++; if (rdata_o !== 32'hA5A5_0001) begin errors++; $display("FAIL rd_rdata_hold got %h exp a5a50001", rdata_o); end
  endtask

  task automatic test_write;
    logic g, rv, er;
    logic [31:0] rd;
    tl_h2d_t a;
    tick;
    do_txn(1'b1, 32'h04, 32'h55, 4'h1, 3'h0, 8'd0, 1'b0, 32'hFFFF_FFFF, g, a, rv, rd, er);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", g); end
    checks++; if (a.a_opcode !== 3'h1) begin errors++; $display("FAIL wr_a_opcode got %h exp 1", a.a_opcode); end
    checks++; if (a.a_mask !== 4'h1) begin errors++; $display("FAIL wr_a_mask got %h exp 1", a.a_mask); end
    checks++; if (a.a_data !== 32'h55) begin errors++; $display("FAIL wr_a_data got %h exp 55", a.a_data); end
    checks++; if (a.a_address !== 32'h04) begin errors++; $display("FAIL wr_a_address got %h exp 4", a.a_address); end
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL wr_rvalid got %b exp 1", rv); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h exp 0", rd); end
  endtask

  task automatic test_backpressure;
    int av_cnt;
    logic stable;
    av_cnt = 0;
    stable = 1'b1;
    tick;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20; be_i = 4'hF; d2h.a_ready = 1'b0;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL bp_gnt got %b exp 1", gnt_o); end
    tick;
    addr_i = 32'hDEAD_BEE0; we_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) d2h.a_ready = 1'b1;
      #1;
      if (h2d.a_valid === 1'b1) av_cnt++;
      if (h2d.a_address !== 32'h20 || h2d.a_opcode !== 3'h4 || h2d.a_mask !== 4'hF) stable = 1'b0;
      checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL bp_gnt_busy cycle %0d got %b exp 0", i, gnt_o); end
      if (i == 5) req_i = 1'b0;
      tick;
    end
    #1;
    checks++; if (av_cnt !== 6) begin errors++; $display("FAIL bp_a_valid_cycles got %0d exp 6", av_cnt); end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_fields_stable got %b exp 1", stable); end
    checks++; if (h2d.a_valid !== 1'b0) begin errors++; $display("FAIL bp_a_valid_after got %b exp 0", h2d.a_valid); end
    d2h.d_valid = 1'b1; d2h.d_opcode = 3'h1; d2h.d_source = 8'd0; d2h.d_data = 32'h1234;
    tick;
    d2h.d_valid = 1'b0;
    #1;
    checks++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h1234) begin errors++; $display("FAIL bp_resp got %b/%h exp 1/00001234", rvalid_o, rdata_o); end
  endtask

  task automatic test_errors;
    logic g, rv, er;
    logic [31:0] rd;
    tl_h2d_t a;
    tick;
    do_txn(1'b0, 32'h40, 32'h0, 4'hF, 3'h1, 8'd0, 1'b1, 32'h1111, g, a, rv, rd, er);
    checks++; if (rv !== 1'b1 || er !== 1'b1) begin errors++; $display("FAIL err_d_error got %b/%b exp 1/1", rv, er); end
    do_txn(1'b0, 32'h44, 32'h0, 4'hF, 3'h1, 8'd1, 1'b0, 32'h2222, g, a, rv, rd, er);
    checks++; if (rv !== 1'b1 || er !== 1'b1) begin errors++; $display("FAIL err_source got %b/%b exp 1/1", rv, er); end
    checks++; if (rd !== 32'h2222) begin errors++; $display("FAIL err_source_rdata got %h exp 2222", rd); end
    do_txn(1'b0, 32'h48, 32'h0, 4'hF, 3'h0, 8'd0, 1'b0, 32'h3333, g, a, rv, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_rd_opcode got %b exp 1", er); end
    do_txn(1'b1, 32'h4C, 32'h9, 4'h3, 3'h1, 8'd0, 1'b0, 32'h0, g, a, rv, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_wr_opcode got %b exp 1", er); end
    do_txn(1'b0, 32'h50, 32'h0, 4'hF, 3'h1, 8'd0, 1'b0, 32'h4444, g, a, rv, rd, er);
    checks++; if (rv !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL err_clear got %b/%b exp 1/0", rv, er); end
  endtask

  task automatic test_reset_mid;
    tick;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h30; be_i = 4'hF; d2h.a_ready = 1'b1;
    tick;
    req_i = 1'b0;
    tick;
    #1;
    checks++; if (busy_o !== 1'b1 || h2d.d_ready !== 1'b1) begin errors++; $display("FAIL rm_in_data got %b/%b exp 1/1", busy_o, h2d.d_ready); end
    d2h.d_valid = 1'b1; d2h.d_opcode = 3'h1; d2h.d_data = 32'hDEAD;
    rst_ni = 1'b0;
    #1;
    checks++; if (h2d.a_valid !== 1'b0 || h2d.d_ready !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rm_async got %b/%b/%b exp 0/0/0", h2d.a_valid, h2d.d_ready, busy_o); end
    tick;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rvalid_o !== 1'b0 || h2d.d_ready !== 1'b0) begin
        errors++; $display("FAIL rm_no_rvalid cycle %0d got %b/%b exp 0/0", i, rvalid_o, h2d.d_ready); end
      tick;
    end
    d2h.d_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic g, rv, er;
    logic [31:0] rd;
    tl_h2d_t a;
    tick;
    do_txn(1'b1, 32'h08, 32'hCAFE_F00D, 4'hF, 3'h0, 8'd0, 1'b0, 32'h0, g, a, rv, rd, er);
    checks++; if (a.a_opcode !== 3'h0 || a.a_data !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL b2b_full got %h/%h exp 0/cafef00d", a.a_opcode, a.a_data); end
    checks++; if (rv !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL b2b_wr_resp got %b/%b exp 1/0", rv, er); end
    do_txn(1'b0, 32'h0C, 32'h0, 4'hF, 3'h1, 8'd0, 1'b0, 32'h0000_0077, g, a, rv, rd, er);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL b2b_gnt_t3 got %b exp 1", g); end
    checks++; if (a.a_address !== 32'h0C || rd !== 32'h77) begin
      errors++; $display("FAIL b2b_rd got %h/%h exp c/77", a.a_address, rd); end
  endtask

  task automatic test_align;
`ifdef TLUL_HOST_ALIGN_CHK_EN
    tick;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h13; be_i = 4'hF; d2h.a_ready = 1'b1;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL al_gnt got %b exp 1", gnt_o); end
    tick;
    req_i = 1'b0;
    #1;
    checks++; if (rvalid_o !== 1'b1 || err_o !== 1'b1 || rdata_o !== 32'h0) begin
      errors++; $display("FAIL al_resp got %b/%b/%h exp 1/1/0", rvalid_o, err_o, rdata_o); end
    checks++; if (h2d.a_valid !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL al_no_a got %b/%b exp 0/0", h2d.a_valid, busy_o); end
    tick;
    #1;
    checks++; if (h2d.a_valid !== 1'b0 || rvalid_o !== 1'b0) begin
      errors++; $display("FAIL al_quiet got %b/%b exp 0/0", h2d.a_valid, rvalid_o); end
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h14; be_i = 4'h0;
    tick;
    req_i = 1'b0;
    #1;
    checks++; if (rvalid_o !== 1'b1 || err_o !== 1'b1 || h2d.a_valid !== 1'b0) begin
      errors++; $display("FAIL al_be0 got %b/%b/%b exp 1/1/0", rvalid_o, err_o, h2d.a_valid); end
`else
    logic g, rv, er;
    logic [31:0] rd;
    tl_h2d_t a;
    tick;
    do_txn(1'b0, 32'h13, 32'h0, 4'hF, 3'h1, 8'd0, 1'b0, 32'h0BAD, g, a, rv, rd, er);
    checks++; if (a.a_valid !== 1'b1 || a.a_address !== 32'h13) begin
      errors++; $display("FAIL al_pass_addr got %b/%h exp 1/13", a.a_valid, a.a_address); end
    checks++; if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0BAD) begin
      errors++; $display("FAIL al_pass_resp got %b/%b/%h exp 1/0/bad", rv, er, rd); end
    do_txn(1'b1, 32'h14, 32'h1, 4'h0, 3'h0, 8'd0, 1'b0, 32'h0, g, a, rv, rd, er);
    checks++; if (a.a_mask !== 4'h0 || a.a_opcode !== 3'h1 || er !== 1'b0) begin
      errors++; $display("FAIL al_pass_be0 got %h/%h/%b exp 0/1/0", a.a_mask, a.a_opcode, er); end
`endif
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
